// File: rtl/image_line_fetch.sv
// Per-line SDRAM prefetch: on hblank rise, bursts the next line's words and packs
// background/mask bytes into 24-bit pixels. Optional IMAGE_LINE_FETCH_UNDERRUN_STATS_EN adds underrun_count.
module image_line_fetch #(
    parameter int unsigned LINE_PIXELS = 720,
    parameter int unsigned LINE_COUNT  = 720
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hblank,
    input  logic [9:0]  video_y,
    output logic        sd_rd,
    output logic        sd_end_burst,
    output logic [24:0] sd_addr,
    input  logic        sd_data_available,
    input  logic [15:0] sd_q,
    output logic [23:0] bg_pixel,
    output logic [23:0] mask_pixel,
    output logic        pixel_valid,
    output logic        fifo_clear,
    output logic        line_done,
`ifdef IMAGE_LINE_FETCH_UNDERRUN_STATS_EN
    output logic [15:0] underrun_count,
`endif
    output logic        busy
);

    localparam int unsigned WPL = LINE_PIXELS * 3;
    localparam int unsigned CW  = $clog2(WPL + 1);
    localparam int unsigned AW  = 25;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BURST,
        S_DONE
    } state_t;

    state_t         r_state;
    logic           r_prev_hblank;
    logic           r_prev_dav;
    logic [CW-1:0]  r_read_count;
    logic [1:0]     r_byte_phase;
    logic [15:0]    r_bg_sr;
    logic [15:0]    r_mask_sr;
    logic [AW-1:0]  r_base;

    logic           w_ls;
    logic [9:0]     w_next_y;
    logic [AW-1:0]  w_next_base;
    logic           w_beat;
    logic           w_dav_fall;
    logic           w_end_near;

    // Line start and per-beat qualifiers
    assign w_ls        = hblank & ~r_prev_hblank;
    assign w_next_y    = (32'(video_y) >= LINE_COUNT - 1) ? 10'd0 : video_y + 10'd1;
    assign w_next_base = AW'(w_next_y) * AW'(WPL);
    assign w_beat      = sd_data_available && (r_read_count < CW'(WPL));
    assign w_dav_fall  = r_prev_dav & ~sd_data_available;
    assign w_end_near  = r_read_count >= CW'(WPL - 2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_prev_hblank <= 1'b0;
            r_prev_dav    <= 1'b0;
            r_read_count  <= '0;
            r_byte_phase  <= 2'd0;
            r_bg_sr       <= 16'd0;
            r_mask_sr     <= 16'd0;
            r_base        <= '0;
            sd_rd         <= 1'b0;
            sd_end_burst  <= 1'b0;
            sd_addr       <= '0;
            bg_pixel      <= 24'd0;
            mask_pixel    <= 24'd0;
            pixel_valid   <= 1'b0;
            fifo_clear    <= 1'b0;
            line_done     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            r_prev_hblank <= hblank;
            r_prev_dav    <= sd_data_available;
            sd_rd         <= 1'b0;
            sd_end_burst  <= 1'b0;
            pixel_valid   <= 1'b0;
            fifo_clear    <= 1'b0;
            line_done     <= 1'b0;

            // Line start overrides any state and discards a coincident beat
            if (w_ls) begin
                fifo_clear   <= 1'b1;
                r_read_count <= '0;
                r_byte_phase <= 2'd0;
                r_bg_sr      <= 16'd0;
                r_mask_sr    <= 16'd0;
                r_base       <= w_next_base;
                busy         <= 1'b1;
                sd_end_burst <= (r_state == S_BURST);
                r_state      <= S_REQ;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_REQ: begin
                        sd_rd   <= 1'b1;
                        sd_addr <= r_base + AW'(r_read_count);
                        r_state <= S_BURST;
                    end
                    S_BURST: begin
                        if (w_beat) begin
                            r_bg_sr      <= {r_bg_sr[7:0], sd_q[7:0]};
                            r_mask_sr    <= {r_mask_sr[7:0], sd_q[15:8]};
                            r_read_count <= r_read_count + CW'(1);
                            if (w_end_near) begin
                                sd_end_burst <= 1'b1;
                            end
                            if (r_byte_phase == 2'd2) begin
                                r_byte_phase <= 2'd0;
                                bg_pixel     <= {r_bg_sr, sd_q[7:0]};
                                mask_pixel   <= {r_mask_sr, sd_q[15:8]};
                                pixel_valid  <= 1'b1;
                            end else begin
                                r_byte_phase <= r_byte_phase + 2'd1;
                            end
                        end else if (w_dav_fall) begin
                            // Controller ended the burst early: resume where we stopped
                            if (r_read_count < CW'(WPL)) begin
                                r_state <= S_REQ;
                            end else begin
                                r_state <= S_DONE;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    S_DONE: begin
                        line_done <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef IMAGE_LINE_FETCH_UNDERRUN_STATS_EN
    // Counts lines abandoned before all words arrived
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_count <= 16'd0;
        end else if (w_ls && (r_state == S_REQ || r_state == S_BURST)
                     && underrun_count != 16'hFFFF) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_image_line_fetch.sv
// Scoreboard bench for image_line_fetch: expected pixels queued as beats are driven,
// popped as pixel_valid strobes appear.
module tb_image_line_fetch;

    localparam int WPL = 2160;

    logic        clk;
    logic        reset;
    logic        hblank;
    logic [9:0]  video_y;
    logic        sd_rd;
    logic        sd_end_burst;
    logic [24:0] sd_addr;
    logic        sd_data_available;
    logic [15:0] sd_q;
    logic [23:0] bg_pixel;
    logic [23:0] mask_pixel;
    logic        pixel_valid;
    logic        fifo_clear;
    logic        line_done;
    logic        busy;
`ifdef IMAGE_LINE_FETCH_UNDERRUN_STATS_EN
    logic [15:0] underrun_count;
`endif

    image_line_fetch #(.LINE_PIXELS(720), .LINE_COUNT(720)) dut (
        .clk               (clk),
        .reset             (reset),
        .hblank            (hblank),
        .video_y           (video_y),
        .sd_rd             (sd_rd),
        .sd_end_burst      (sd_end_burst),
        .sd_addr           (sd_addr),
        .sd_data_available (sd_data_available),
        .sd_q              (sd_q),
        .bg_pixel          (bg_pixel),
        .mask_pixel        (mask_pixel),
        .pixel_valid       (pixel_valid),
        .fifo_clear        (fifo_clear),
        .line_done         (line_done),
`ifdef IMAGE_LINE_FETCH_UNDERRUN_STATS_EN
        .underrun_count    (underrun_count),
`endif
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [47:0] exp_q[$];
    int          cyc = 0;
    int          rd_cnt = 0;
    int          rd_cyc = 0;
    logic [24:0] last_addr = '0;
    int          fc_cnt = 0;
    int          fc_cyc = 0;
    logic        fc_eb = 1'b0;
    int          eb_cnt = 0;
    int          first_eb_k = -1;
    int          cur_k = -1;
    int          ld_cnt = 0;
    logic        ld_busy = 1'b0;
    int          pix_cnt = 0;
    int          line_pix = 0;
    logic [23:0] first_bg = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] beat(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {~b, b};
    endfunction

    function automatic logic [47:0] exp_pix(input int k);
        logic [23:0] bg;
        bg = {8'(k - 2), 8'(k - 1), 8'(k)};
        return {bg, ~bg};
    endfunction

    // Advance one clock and observe outputs 1 ns after the edge
    task automatic tick();
        logic [47:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (sd_rd) begin
            rd_cnt++;
            rd_cyc    = cyc;
            last_addr = sd_addr;
        end
        if (fifo_clear) begin
            fc_cnt++;
            fc_cyc     = cyc;
            fc_eb      = sd_end_burst;
            first_eb_k = -1;
            line_pix   = 0;
        end
        if (sd_end_burst) begin
            eb_cnt++;
            if (first_eb_k < 0 && !fifo_clear) first_eb_k = cur_k;
        end
        if (line_done) begin
            ld_cnt++;
            ld_busy = busy;
        end
        if (pixel_valid) begin
            pix_cnt++;
            if (line_pix == 0) first_bg = bg_pixel;
            line_pix++;
            check_eq("pv_vs_clear", 64'(fifo_clear), 64'd0);
            if (exp_q.size() == 0) begin
                check_eq("pix_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("pixel", 64'({bg_pixel, mask_pixel}), 64'(e));
            end
        end
    endtask

    task automatic line_start(input int y);
        video_y = 10'(y);
        hblank  = 1'b1;
        tick();
        hblank  = 1'b0;
    endtask

    task automatic wait_rd(input int n);
        for (int i = 0; i < 200 && rd_cnt < n; i++) tick();
        check_eq("sd_rd_seen", 64'(rd_cnt >= n), 64'd1);
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 200 && ld_cnt < n; i++) tick();
        check_eq("line_done_seen", 64'(ld_cnt), 64'(n));
        check_eq("busy_at_done", 64'(ld_busy), 64'd0);
    endtask

    task automatic burst(input int k0, input int k1, input bit drop, input bit push_en);
        for (int k = k0; k <= k1; k++) begin
            sd_data_available = 1'b1;
            sd_q  = beat(k);
            cur_k = k;
            if (push_en && (k % 3 == 2) && k < WPL) exp_q.push_back(exp_pix(k));
            tick();
        end
        if (drop) begin
            sd_data_available = 1'b0;
            cur_k = -1;
            tick();
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_sd_rd"}, 64'(sd_rd), 64'd0);
        check_eq({tag, "_eb"}, 64'(sd_end_burst), 64'd0);
        check_eq({tag, "_addr"}, 64'(sd_addr), 64'd0);
        check_eq({tag, "_pix"}, 64'({bg_pixel, mask_pixel}), 64'd0);
        check_eq({tag, "_pv"}, 64'(pixel_valid), 64'd0);
        check_eq({tag, "_fc"}, 64'(fifo_clear), 64'd0);
        check_eq({tag, "_ld"}, 64'(line_done), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
`ifdef IMAGE_LINE_FETCH_UNDERRUN_STATS_EN
        check_eq({tag, "_underrun"}, 64'(underrun_count), 64'd0);
`endif
    endtask

    initial begin
        int rd0;
        int pix0;
        int eb0;
        reset             = 1'b1;
        hblank            = 1'b0;
        video_y           = 10'd0;
        sd_data_available = 1'b0;
        sd_q              = 16'd0;
        repeat (3) tick();
        check_quiet("reset");
        reset = 1'b0;
        tick();

        // Single full burst, line 5 -> fetch line 6
        line_start(5);
        check_eq("fifo_clear", 64'(fifo_clear), 64'd1);
        check_eq("busy_start", 64'(busy), 64'd1);
        wait_rd(1);
        check_eq("ls_to_rd", 64'(rd_cyc - fc_cyc), 64'd1);
        check_eq("addr_y6", 64'(last_addr), 64'd12960);
        burst(0, WPL - 1, 1'b1, 1'b1);
        wait_done(1);
        check_eq("first_bg", 64'(first_bg), 64'h000102);
        check_eq("line_pix_a", 64'(line_pix), 64'd720);
        check_eq("first_eb_k", 64'(first_eb_k), 64'd2158);
        repeat (20) tick();
        check_eq("no_extra_rd", 64'(rd_cnt), 64'd1);
        check_eq("ld_once", 64'(ld_cnt), 64'd1);

        // Burst interrupted after 1000 beats and resumed
        line_start(5);
        wait_rd(2);
        burst(0, 999, 1'b1, 1'b1);
        wait_rd(3);
        check_eq("addr_resume", 64'(last_addr), 64'd13960);
        burst(1000, WPL - 1, 1'b1, 1'b1);
        wait_done(2);
        check_eq("line_pix_b", 64'(line_pix), 64'd720);

        // Wrap at last line, with surplus beats past the line end
        line_start(719);
        wait_rd(4);
        check_eq("addr_wrap719", 64'(last_addr), 64'd0);
        burst(0, WPL + 1, 1'b1, 1'b1);
        wait_done(3);
        check_eq("line_pix_c", 64'(line_pix), 64'd720);
        check_eq("first_eb_k_c", 64'(first_eb_k), 64'd2158);
        line_start(800);
        wait_rd(5);
        check_eq("addr_wrap800", 64'(last_addr), 64'd0);
        burst(0, WPL - 1, 1'b1, 1'b1);
        wait_done(4);

        // New line start coinciding with beat 500
        line_start(10);
        wait_rd(6);
        check_eq("addr_y11", 64'(last_addr), 64'd23760);
        burst(0, 499, 1'b0, 1'b1);
        sd_q    = beat(500);
        cur_k   = 500;
        video_y = 10'd20;
        hblank  = 1'b1;
        tick();
        check_eq("collide_fc", 64'(fifo_clear), 64'd1);
        check_eq("collide_eb", 64'(fc_eb), 64'd1);
        check_eq("collide_q_empty", 64'(exp_q.size()), 64'd0);
        sd_data_available = 1'b0;
        hblank = 1'b0;
        cur_k  = -1;
        tick();
        wait_rd(7);
        check_eq("addr_y21", 64'(last_addr), 64'd45360);
`ifdef IMAGE_LINE_FETCH_UNDERRUN_STATS_EN
        check_eq("underrun_1", 64'(underrun_count), 64'd1);
`endif
        burst(0, WPL - 1, 1'b1, 1'b1);
        wait_done(5);
        check_eq("line_pix_d", 64'(line_pix), 64'd720);

        // Reset mid-burst, then stray beats must be ignored
        line_start(3);
        wait_rd(8);
        check_eq("addr_y4", 64'(last_addr), 64'd8640);
        burst(0, 299, 1'b0, 1'b1);
        reset = 1'b1;
        sd_q  = beat(300);
        cur_k = 300;
        tick();
        check_quiet("midreset");
        reset = 1'b0;
        rd0  = rd_cnt;
        pix0 = pix_cnt;
        eb0  = eb_cnt;
        burst(301, 399, 1'b1, 1'b0);
        repeat (5) tick();
        check_eq("post_reset_rd", 64'(rd_cnt), 64'(rd0));
        check_eq("post_reset_pix", 64'(pix_cnt), 64'(pix0));
        check_eq("post_reset_eb", 64'(eb_cnt), 64'(eb0));
        check_eq("post_reset_busy", 64'(busy), 64'd0);
        check_eq("post_reset_q", 64'(exp_q.size()), 64'd0);
        line_start(4);
        wait_rd(rd0 + 1);
        check_eq("addr_y5", 64'(last_addr), 64'd10800);
        burst(0, WPL - 1, 1'b1, 1'b1);
        wait_done(6);
        check_eq("line_pix_e", 64'(line_pix), 64'd720);
        repeat (5) tick();
        check_eq("final_q_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
